// File: rtl/vc_bus_pkg.sv
// vc_bus_pkg: shared FSM state encoding and timer register addresses for vc_bus_target.
package vc_bus_pkg;
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_DATA
   } vc_state_e;
   localparam logic [15:0] VC_TMR_LO_ADDR = 16'hFFFE;
   localparam logic [15:0] VC_TMR_HI_ADDR = 16'hFFFF;
endpackage

// File: rtl/vc_bus_target_ram.sv
// vc_bus_target_ram: byte RAM, one synchronous write port and one asynchronous read port.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write byte address
//   wdata_i  : write byte
//   raddr_i  : read byte address
//   rdata_o  : read byte (combinational)
module vc_bus_target_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [7:0]        rdata_o
);
   logic [7:0] mem_q [2**ADDR_W];
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/vc_bus_target.sv
// vc_bus_target: memory-side target for the 8-bit multiplexed CPU bus (address latches, byte SRAM, protocol monitor).
//   clk       : clock, all state on posedge
//   rst_n     : asynchronous active-low reset
//   bus_in    : multiplexed address/data byte from the CPU
//   latch_hi  : bus_in carries addr[15:8]
//   latch_lo  : bus_in carries {addr[7:1], byte_sel}
//   write     : bus_in carries write data
//   ind       : select high byte of the word (forces address bit 0)
//   rd_data   : combinational read byte, 0 while in reset
//   irq       : timer interrupt
//   err       : sticky protocol-violation flag
//   wr_count  : completed write transactions (wraps)
//   rd_count  : completed read transactions (wraps)
// Optional feature macro VC_TGT_TIMER_IRQ_EN: 16-bit down-timer at 16'hFFFE/16'hFFFF driving irq;
// when undefined irq is tied low and those addresses alias into RAM.
module vc_bus_target
   import vc_bus_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       bus_in,
   input  logic             latch_hi,
   input  logic             latch_lo,
   input  logic             write,
   input  logic             ind,
   output logic [7:0]       rd_data,
   output logic             irq,
   output logic             err,
   output logic [CNT_W-1:0] wr_count,
   output logic [CNT_W-1:0] rd_count
);
   vc_state_e        state_q, state_d;
   logic [7:0]       a_hi_q, a_lo_q, eff_hi, eff_lo, ram_rdata, rd_byte;
   logic [15:0]      ba;
   logic             err_q, err_d, wr_ok, tmr_hit, ram_we, unused_ba;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   // Strobed bytes pass straight through, emulating transparent address latches.
   assign eff_hi    = latch_hi ? bus_in : a_hi_q;
   assign eff_lo    = latch_lo ? bus_in : a_lo_q;
   assign ba        = {eff_hi, eff_lo[7:1], eff_lo[0] | ind};
   assign unused_ba = ^ba;
   assign wr_ok     = write && (state_q == ST_ADDR_LO || state_q == ST_DATA);
   assign ram_we    = wr_ok && !tmr_hit;
   vc_bus_target_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ba[ADDR_W-1:0]),
      .wdata_i (bus_in),
      .raddr_i (ba[ADDR_W-1:0]),
      .rdata_o (ram_rdata)
   );
   always_comb begin
      state_d  = state_q;
      err_d    = err_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      if (latch_hi) state_d = ST_ADDR_HI;
      else begin
         case (state_q)
            ST_IDLE: if (write) err_d = 1'b1;
            ST_ADDR_HI: begin
               state_d = latch_lo ? ST_ADDR_LO : ST_IDLE;
               if (!latch_lo || write) err_d = 1'b1;
            end
            ST_ADDR_LO: begin
               if (write) begin
                  state_d  = ST_DATA;
                  wr_cnt_d = wr_cnt_q + CNT_W'(1);
               end else if (ind) begin
                  state_d  = ST_DATA;
                  rd_cnt_d = rd_cnt_q + CNT_W'(1);
               end else if (!latch_lo) begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
            end
            ST_DATA: state_d = (write && ind) ? ST_DATA : ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_hi_q   <= 8'h00;
         a_lo_q   <= 8'h00;
         err_q    <= 1'b0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         a_hi_q   <= eff_hi;
         a_lo_q   <= eff_lo;
         err_q    <= err_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end
`ifdef VC_TGT_TIMER_IRQ_EN
   logic [15:0] tmr_q, tmr_d;
   logic [7:0]  stg_q, stg_d;
   logic        irq_q, irq_d, tmr_we_lo, tmr_we_hi;
   // Timer decode uses the full 16-bit address, ahead of RAM aliasing.
   assign tmr_hit   = (ba == VC_TMR_LO_ADDR) || (ba == VC_TMR_HI_ADDR);
   assign tmr_we_lo = wr_ok && (ba == VC_TMR_LO_ADDR);
   assign tmr_we_hi = wr_ok && (ba == VC_TMR_HI_ADDR);
   always_comb begin
      stg_d = tmr_we_lo ? bus_in : stg_q;
      tmr_d = tmr_we_hi ? {bus_in, stg_q} : (tmr_q != 16'd0) ? tmr_q - 16'd1 : tmr_q;
      irq_d = tmr_we_lo ? 1'b0 : (!tmr_we_hi && tmr_q == 16'd1) ? 1'b1 : irq_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_q <= 16'd0;
         stg_q <= 8'h00;
         irq_q <= 1'b0;
      end else begin
         tmr_q <= tmr_d;
         stg_q <= stg_d;
         irq_q <= irq_d;
      end
   end
   assign irq     = irq_q;
   assign rd_byte = tmr_hit ? (ba[0] ? tmr_q[15:8] : tmr_q[7:0]) : ram_rdata;
`else
   assign tmr_hit = 1'b0;
   assign irq     = 1'b0;
   assign rd_byte = ram_rdata;
`endif
   assign rd_data  = rst_n ? rd_byte : 8'h00;
   assign err      = err_q;
   assign wr_count = wr_cnt_q;
   assign rd_count = rd_cnt_q;
endmodule
